// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver (idle high, one start bit,
// DATA_WIDTH data bits LSB first, one stop bit). Each bit is sampled once near its
// centre; the tick grid is re-aligned to every start edge. Good words are presented on
// data_o with a one-clock rx_valid strobe. A bad stop bit raises a one-clock frame_err.
module uart_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int BAUDRATE     = 9600,
    parameter int CLK_FREQ_MHZ = 125,
    parameter int OVERSAMPLE   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rx_valid,
    output logic                  rx_busy,
    output logic                  frame_err
);

    localparam int TICK_RAW   = (CLK_FREQ_MHZ * 1_000_000) / (BAUDRATE * OVERSAMPLE);
    localparam int TICK_COUNT = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int TICK_W     = $clog2(TICK_COUNT + 1);
    localparam int OS_W       = $clog2(OVERSAMPLE + 1);
    localparam int BIT_W      = $clog2(DATA_WIDTH + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_COUNT - 1);
    localparam logic [OS_W-1:0]   OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Synchroniser and edge-detect history
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;

    // Receiver state
    state_t                  state_q,    state_d;
    logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic [OS_W-1:0]         os_cnt_q,   os_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q,    shift_d;
    logic [DATA_WIDTH-1:0]   data_q,     data_d;
    logic                    valid_q,    valid_d;
    logic                    err_q,      err_d;
    logic                    busy_q,     busy_d;

    logic tick;
    logic fall;

    assign tick = (tick_cnt_q == TICK_LAST);
    assign fall = rx_prev_q & ~rx_s_q;

    // Next-state and next-output computation for the whole receiver
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    os_cnt_d   = '0;
                end
            end

            S_START: begin
                if (tick) begin
                    if (os_cnt_q == OS_MID) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        state_d   = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end

            S_DATA: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d = '0;
                        shift_d  = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end

            S_STOP: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d = '0;
                        state_d  = S_IDLE;
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Register synchroniser, FSM state, counters and outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: synchroniser flops reset to the idle line level (1) so releasing
            // reset can never look like a start edge.
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values;
            // blocking here would collapse the synchroniser chain into one stage.
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign data_o    = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = err_q;
    assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames (directed and random) at 16 clk/bit and checks the
// receiver against a frame-level model: a queue of expected strobes, each with the
// clock at which it must appear, and the last good word data_o must hold.
module tb_uart_rx;

    localparam int BIT_CLKS = 16;
    // pin fall -> strobe: 2 sync + half start bit + 8 data + stop bit + 1 output reg
    localparam int LAT      = 2 + BIT_CLKS / 2 + BIT_CLKS * 9 + 1;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_o;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    uart_rx #(
        .DATA_WIDTH  (8),
        .BAUDRATE    (62500),
        .CLK_FREQ_MHZ(1),
        .OVERSAMPLE  (16)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (rx),
        .data_o   (data_o),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         t;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e_cur;
    logic [7:0] model_data = 8'h00;
    bit         prev_strobe = 1'b0;
    int         n_valid = 0;
    int         n_err = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Compare process: outputs versus the frame-level model on every falling edge
    always @(negedge clk) begin
        if (!rstn) begin
            check("reset_outputs", 32'({data_o, rx_valid, rx_busy, frame_err}), 32'd0);
            exp_q.delete();
            model_data  = 8'h00;
            prev_strobe = 1'b0;
        end else begin
            if (rx_valid || frame_err) begin
                check("strobe_exclusive", 32'(rx_valid & frame_err), 32'd0);
                check("strobe_one_clk", 32'(prev_strobe), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(frame_err), 32'd2);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("strobe_kind_err", 32'(frame_err), 32'(e_cur.err));
                    check("strobe_time", 32'(cyc), 32'(e_cur.t));
                    if (!e_cur.err) model_data = e_cur.data;
                    if (rx_valid) n_valid++;
                    else n_err++;
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].t) begin
                check("strobe_missing_at", 32'(cyc), 32'(exp_q[0].t));
                void'(exp_q.pop_front());
            end
            check("data_o", 32'(data_o), 32'(model_data));
            prev_strobe = rx_valid | frame_err;
        end
    end

    // All stimulus tasks start and end at posedge+1
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_bit);
        exp_q.push_back('{err: !stop_bit, data: d, t: cyc + LAT});
        rx = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic glitch(input int n);
        rx = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    int v0;
    int e0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(10);

        // Test 1: single good frame
        v0 = n_valid; e0 = n_err;
        send_frame(8'hA5, 1'b1);
        idle(4);
        @(negedge clk);
        check("t1_data", 32'(data_o), 32'h0000_00A5);
        check("t1_valid_count", 32'(n_valid - v0), 32'd1);
        check("t1_no_err", 32'(n_err - e0), 32'd0);
        check("t1_busy_low", 32'(rx_busy), 32'd0);
        @(posedge clk); #1;

        // Test 2: short low glitch is rejected at mid start bit
        v0 = n_valid; e0 = n_err;
        glitch(4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t2_busy_during", 32'(rx_busy), 32'd1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t2_busy_after", 32'(rx_busy), 32'd0);
        @(posedge clk); #1;
        idle(200);
        check("t2_no_strobes", 32'((n_valid - v0) + (n_err - e0)), 32'd0);
        check("t2_data_kept", 32'(data_o), 32'h0000_00A5);

        // Test 3: good 0x11 then 0x3C with stop bit 0
        v0 = n_valid; e0 = n_err;
        send_frame(8'h11, 1'b1);
        send_frame(8'h3C, 1'b0);
        idle(20);
        check("t3_data_kept", 32'(data_o), 32'h0000_0011);
        check("t3_err_count", 32'(n_err - e0), 32'd1);
        check("t3_valid_count", 32'(n_valid - v0), 32'd1);

        // Test 4: back-to-back 0x00 then 0xFF
        v0 = n_valid;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check("t4_valid_count", 32'(n_valid - v0), 32'd2);
        check("t4_data", 32'(data_o), 32'h0000_00FF);

        // Test 5: reset during bit 3 of 0x5A (not expected), then 0xC3
        rx = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rx = ((8'h5A >> i) & 8'h01) != 0;
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        check("t5_async_reset_busy", 32'(rx_busy), 32'd0);
        check("t5_async_reset_data", 32'(data_o), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(20);
        check("t5_after_reset_data", 32'(data_o), 32'd0);
        send_frame(8'hC3, 1'b1);
        idle(20);
        check("t5_data", 32'(data_o), 32'h0000_00C3);

        // Line held low: one framing error, then no retrigger while low
        e0 = n_err; v0 = n_valid;
        exp_q.push_back('{err: 1'b1, data: 8'h00, t: cyc + LAT});
        rx = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        idle(40);
        check("held_low_err_count", 32'(n_err - e0), 32'd1);
        check("held_low_no_valid", 32'(n_valid - v0), 32'd0);

        // Test 6: random frames, random gaps (including none), occasional glitches
        for (int k = 0; k < 40; k++) begin
            logic [7:0] d;
            bit         stop_bit;
            d        = 8'($urandom);
            stop_bit = ($urandom_range(0, 7) != 0);
            send_frame(d, stop_bit);
            if (!stop_bit) idle($urandom_range(2, 20));
            else if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 20));
            if ($urandom_range(0, 5) == 0) begin
                glitch($urandom_range(1, 7));
                idle(20);
            end
        end
        idle(300);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
